// File: rtl/halut_result_gather_if.sv
// Result-gather bus: parallel decoder write channels plus the drained-row output stream.
interface halut_result_gather_if #(
  parameter int M         = 32,
  parameter int NumCh     = 2,
  parameter int DataWidth = 32
);
  localparam int MAddrWidth = $clog2(M);

  logic [NumCh-1:0]                 ch_valid;
  logic [NumCh-1:0][MAddrWidth-1:0] ch_m_addr;
  logic [NumCh-1:0][DataWidth-1:0]  ch_data;
  logic                             accept;
  logic                             out_valid;
  logic                             out_ready;
  logic [DataWidth-1:0]             out_data;
  logic [MAddrWidth-1:0]            out_m_addr;
  logic                             out_last;

  modport master (
    output ch_valid, ch_m_addr, ch_data, out_ready,
    input  accept, out_valid, out_data, out_m_addr, out_last
  );

  modport slave (
    input  ch_valid, ch_m_addr, ch_data, out_ready,
    output accept, out_valid, out_data, out_m_addr, out_last
  );
endinterface

// File: rtl/halut_result_gather.sv
// Double-buffered gather of per-channel decoder results into M-column rows,
// drained in column order over a valid/ready stream with sticky error flags.
module halut_result_gather #(
  parameter int M         = 32,
  parameter int NumCh     = 2,
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  halut_result_gather_if.slave bus,
  output logic [CntWidth-1:0]  row_count_o,
  input  logic                 clear_err_i,
  output logic                 dup_err_o,
  output logic                 range_err_o,
  output logic                 ovf_err_o
);
  localparam int MAddrWidth = $clog2(M);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e              st_q [2];
  bank_st_e              st_d [2];
  logic [M-1:0]          bm_q [2];
  logic [M-1:0]          bm_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [MAddrWidth-1:0] idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DataWidth-1:0]  mem_q [2][M];

  logic [NumCh-1:0] win;
  logic [M-1:0]     wmask, new_bm;
  logic             accept, out_valid, xfer, last;
  logic             dup_hit, range_hit, ovf_hit, complete;

  assign accept    = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
  assign out_valid = (st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING);
  assign last      = out_valid && (idx_q == MAddrWidth'(M - 1));
  assign xfer      = out_valid && bus.out_ready;

  // Channels are scanned in index order so a lower channel claims a column
  // first; a later channel hitting the same column is dropped as a duplicate.
  always_comb begin
    win       = '0;
    wmask     = '0;
    dup_hit   = 1'b0;
    range_hit = 1'b0;
    ovf_hit   = 1'b0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (bus.ch_valid[c]) begin
        if (!accept) begin
          ovf_hit = 1'b1;
        end else if (32'(bus.ch_m_addr[c]) >= 32'(M)) begin
          range_hit = 1'b1;
        end else if (wmask[bus.ch_m_addr[c]]) begin
          dup_hit = 1'b1;
        end else begin
          if (bm_q[wr_bank_q][bus.ch_m_addr[c]]) dup_hit = 1'b1;
          win[c]                   = 1'b1;
          wmask[bus.ch_m_addr[c]] = 1'b1;
        end
      end
    end
    new_bm   = bm_q[wr_bank_q] | wmask;
    complete = (|win) && (&new_bm);
  end

  // Fill and drain never touch the same bank in one cycle: fill needs the
  // bank EMPTY/FILLING, drain needs it FULL/DRAINING.
  always_comb begin
    st_d      = st_q;
    bm_d      = bm_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    if (|win) begin
      st_d[wr_bank_q] = FILLING;
      bm_d[wr_bank_q] = new_bm;
      if (complete) begin
        st_d[wr_bank_q] = FULL;
        bm_d[wr_bank_q] = '0;
        wr_bank_d       = ~wr_bank_q;
      end
    end
    if (xfer) begin
      st_d[rd_bank_q] = DRAINING;
      idx_d           = idx_q + 1'b1;
      if (last) begin
        st_d[rd_bank_q] = EMPTY;
        idx_d           = '0;
        rd_bank_d       = ~rd_bank_q;
        cnt_d           = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      bm_q[0]     <= '0;
      bm_q[1]     <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      dup_err_o   <= 1'b0;
      range_err_o <= 1'b0;
      ovf_err_o   <= 1'b0;
    end else begin
      st_q        <= st_d;
      bm_q        <= bm_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dup_err_o   <= dup_hit   | (dup_err_o   & ~clear_err_i);
      range_err_o <= range_hit | (range_err_o & ~clear_err_i);
      ovf_err_o   <= ovf_hit   | (ovf_err_o   & ~clear_err_i);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (win[c]) mem_q[wr_bank_q][bus.ch_m_addr[c]] <= bus.ch_data[c];
    end
  end

  assign bus.accept     = accept;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? mem_q[rd_bank_q][idx_q] : '0;
  assign bus.out_m_addr = idx_q;
  assign bus.out_last   = last;
  assign row_count_o    = cnt_q;
endmodule

// File: tb/tb_halut_result_gather.sv
// Directed bench for halut_result_gather: an M=32 instance for the main
// scenarios and an M=24 instance for out-of-range column handling.
module tb_halut_result_gather;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  halut_result_gather_if #(.M(32), .NumCh(2), .DataWidth(32)) b32 ();
  halut_result_gather_if #(.M(24), .NumCh(2), .DataWidth(32)) b24 ();

  logic [15:0] rc32, rc24;
  logic        dup32, rng32, ovf32, dup24, rng24, ovf24;

  halut_result_gather #(.M(32), .NumCh(2), .DataWidth(32), .CntWidth(16)) u32 (
    .clk_i(clk), .rst_i(rst), .bus(b32), .row_count_o(rc32), .clear_err_i(clr),
    .dup_err_o(dup32), .range_err_o(rng32), .ovf_err_o(ovf32)
  );

  halut_result_gather #(.M(24), .NumCh(2), .DataWidth(32), .CntWidth(16)) u24 (
    .clk_i(clk), .rst_i(rst), .bus(b24), .row_count_o(rc24), .clear_err_i(clr),
    .dup_err_o(dup24), .range_err_o(rng24), .ovf_err_o(ovf24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic v0, input int a0, input logic [31:0] d0,
                    input logic v1, input int a1, input logic [31:0] d1);
    b32.ch_valid     = {v1, v0};
    b32.ch_m_addr[0] = 5'(a0);
    b32.ch_data[0]   = d0;
    b32.ch_m_addr[1] = 5'(a1);
    b32.ch_data[1]   = d1;
    step();
    b32.ch_valid = '0;
  endtask

  task automatic wr24(input logic v0, input int a0, input logic [31:0] d0,
                      input logic v1, input int a1, input logic [31:0] d1);
    b24.ch_valid     = {v1, v0};
    b24.ch_m_addr[0] = 5'(a0);
    b24.ch_data[0]   = d0;
    b24.ch_m_addr[1] = 5'(a1);
    b24.ch_data[1]   = d1;
    step();
    b24.ch_valid = '0;
  endtask

  task automatic fill_row(input logic [31:0] base);
    for (int k = 0; k < 16; k++)
      wr(1'b1, 2 * k, base + 32'(2 * k), 1'b1, 2 * k + 1, base + 32'(2 * k + 1));
  endtask

  // Expects 32 back-to-back beats with ready held high; column om carries od.
  task automatic drain_row(input string tag, input logic [31:0] base,
                           input int om, input logic [31:0] od);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_valid[%0d]", tag, i), 32'(b32.out_valid), 32'd1);
      chk($sformatf("%s_addr[%0d]", tag, i), 32'(b32.out_m_addr), 32'(i));
      chk($sformatf("%s_data[%0d]", tag, i), b32.out_data, (i == om) ? od : base + 32'(i));
      chk($sformatf("%s_last[%0d]", tag, i), 32'(b32.out_last), 32'(i == 31));
      step();
    end
  endtask

  initial begin
    int  e;
    logic rdy;

    b32.ch_valid = '0; b32.ch_m_addr = '0; b32.ch_data = '0; b32.out_ready = 1'b1;
    b24.ch_valid = '0; b24.ch_m_addr = '0; b24.ch_data = '0; b24.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_accept", 32'(b32.accept), 32'd1);
    chk("rst_valid", 32'(b32.out_valid), 32'd0);
    chk("rst_data", b32.out_data, 32'd0);
    chk("rst_addr", 32'(b32.out_m_addr), 32'd0);
    chk("rst_last", 32'(b32.out_last), 32'd0);
    chk("rst_count", 32'(rc32), 32'd0);
    chk("rst_errs", {29'd0, dup32, rng32, ovf32}, 32'd0);

    // 1: even/odd split fill, one full drain
    for (int k = 0; k < 15; k++)
      wr(1'b1, 2 * k, 32'h3F80_0000 + 32'(2 * k), 1'b1, 2 * k + 1, 32'h3F80_0000 + 32'(2 * k + 1));
    chk("t1_valid_before_final", 32'(b32.out_valid), 32'd0);
    wr(1'b1, 30, 32'h3F80_001E, 1'b1, 31, 32'h3F80_001F);
    drain_row("t1", 32'h3F80_0000, -1, 32'd0);
    chk("t1_count", 32'(rc32), 32'd1);
    chk("t1_idle_valid", 32'(b32.out_valid), 32'd0);
    chk("t1_idle_data", b32.out_data, 32'd0);

    // 2: two rows under backpressure, overflow, then release
    b32.out_ready = 1'b0;
    fill_row(32'h0000_1000);
    chk("t2_accept_mid", 32'(b32.accept), 32'd1);
    fill_row(32'h0000_2000);
    chk("t2_accept_full", 32'(b32.accept), 32'd0);
    wr(1'b1, 0, 32'h0000_0BAD, 1'b0, 0, 32'd0);
    chk("t2_ovf", 32'(ovf32), 32'd1);
    chk("t2_accept_still0", 32'(b32.accept), 32'd0);
    b32.out_ready = 1'b1;
    drain_row("t2r0", 32'h0000_1000, -1, 32'd0);
    chk("t2_accept_after_r0", 32'(b32.accept), 32'd1);
    drain_row("t2r1", 32'h0000_2000, -1, 32'd0);
    chk("t2_count", 32'(rc32), 32'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_ovf_cleared", 32'(ovf32), 32'd0);

    // 3: same-cycle column collision, lowest channel wins
    wr(1'b1, 5, 32'h0000_000A, 1'b1, 5, 32'h0000_000B);
    chk("t3_dup", 32'(dup32), 32'd1);
    for (int k = 0; k < 16; k++)
      wr(1'b1, 2 * k, 32'h300 + 32'(2 * k), (2 * k + 1) != 5, 2 * k + 1, 32'h300 + 32'(2 * k + 1));
    clr = 1'b1;
    b32.out_ready = 1'b0;
    step();
    clr = 1'b0;
    b32.out_ready = 1'b1;
    chk("t3_dup_cleared", 32'(dup32), 32'd0);
    drain_row("t3", 32'h300, 5, 32'h0000_000A);
    chk("t3_count", 32'(rc32), 32'd4);

    // 4: drain with ready asserted ~30% of cycles
    fill_row(32'h0000_4000);
    e = 0;
    for (int n = 0; n < 400 && e < 32; n++) begin
      rdy = ($urandom_range(0, 9) < 3);
      b32.out_ready = rdy;
      chk($sformatf("t4_valid[%0d]", e), 32'(b32.out_valid), 32'd1);
      chk($sformatf("t4_addr[%0d]", e), 32'(b32.out_m_addr), 32'(e));
      chk($sformatf("t4_data[%0d]", e), b32.out_data, 32'h4000 + 32'(e));
      chk($sformatf("t4_last[%0d]", e), 32'(b32.out_last), 32'(e == 31));
      step();
      if (rdy) e++;
    end
    b32.out_ready = 1'b1;
    chk("t4_beats", 32'(e), 32'd32);
    chk("t4_count", 32'(rc32), 32'd5);
    chk("t4_idle_valid", 32'(b32.out_valid), 32'd0);

    // 5: reset mid-fill and mid-drain
    for (int k = 0; k < 10; k++)
      wr(1'b1, 2 * k, 32'h5000 + 32'(2 * k), 1'b1, 2 * k + 1, 32'h5000 + 32'(2 * k + 1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5a_valid", 32'(b32.out_valid), 32'd0);
    chk("t5a_accept", 32'(b32.accept), 32'd1);
    chk("t5a_count", 32'(rc32), 32'd0);
    fill_row(32'h0000_6000);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_addr[%0d]", i), 32'(b32.out_m_addr), 32'(i));
      step();
    end
    chk("t5b_addr_at_reset", 32'(b32.out_m_addr), 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5b_valid", 32'(b32.out_valid), 32'd0);
    chk("t5b_accept", 32'(b32.accept), 32'd1);
    chk("t5b_count", 32'(rc32), 32'd0);
    step();
    step();
    chk("t5b_valid_later", 32'(b32.out_valid), 32'd0);
    fill_row(32'h0000_7000);
    drain_row("t5c", 32'h0000_7000, -1, 32'd0);
    chk("t5c_count", 32'(rc32), 32'd1);

    // 6: M=24 instance, out-of-range column
    wr24(1'b1, 30, 32'h0000_DEAD, 1'b1, 0, 32'h9000);
    chk("t6_range", 32'(rng24), 32'd1);
    for (int k = 0; k < 11; k++)
      wr24(1'b1, 2 * k + 1, 32'h9000 + 32'(2 * k + 1), 1'b1, 2 * k + 2, 32'h9000 + 32'(2 * k + 2));
    chk("t6_not_complete", 32'(b24.out_valid), 32'd0);
    chk("t6_accept", 32'(b24.accept), 32'd1);
    wr24(1'b1, 23, 32'h9017, 1'b0, 0, 32'd0);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t6_valid[%0d]", i), 32'(b24.out_valid), 32'd1);
      chk($sformatf("t6_addr[%0d]", i), 32'(b24.out_m_addr), 32'(i));
      chk($sformatf("t6_data[%0d]", i), b24.out_data, 32'h9000 + 32'(i));
      chk($sformatf("t6_last[%0d]", i), 32'(b24.out_last), 32'(i == 23));
      step();
    end
    chk("t6_count", 32'(rc24), 32'd1);
    chk("t6_dup", 32'(dup24), 32'd0);
    chk("t6_idle_valid", 32'(b24.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
